// File: rtl/mux_16_if.sv
// mux_16_if: operand-select bus between the register-file read port and its consumers.
// Revision: 1.0
`default_nettype none

interface mux_16_if #(
   parameter int WIDTH = 16
);
   logic [3:0]       select;
   logic [WIDTH-1:0] data_out0;
   logic [WIDTH-1:0] data_out1;
   logic [WIDTH-1:0] data_out2;
   logic [WIDTH-1:0] data_out3;
   logic [WIDTH-1:0] data_out4;
   logic [WIDTH-1:0] data_out5;
   logic [WIDTH-1:0] data_out6;
   logic [WIDTH-1:0] data_out7;
   logic [WIDTH-1:0] data_out8;
   logic [WIDTH-1:0] data_out9;
   logic [WIDTH-1:0] data_out10;
   logic [WIDTH-1:0] data_out11;
   logic [WIDTH-1:0] data_out12;
   logic [WIDTH-1:0] data_out13;
   logic [WIDTH-1:0] data_out14;
   logic [WIDTH-1:0] data_out15;
   logic             capture;
   logic [WIDTH-1:0] out;
   logic [WIDTH-1:0] out_q;
   logic [3:0]       sel_q;

   modport master (
      output select, capture,
      output data_out0, data_out1, data_out2,  data_out3,  data_out4,  data_out5,  data_out6,  data_out7,
      output data_out8, data_out9, data_out10, data_out11, data_out12, data_out13, data_out14, data_out15,
      input  out, out_q, sel_q
   );

   modport slave (
      input  select, capture,
      input  data_out0, data_out1, data_out2,  data_out3,  data_out4,  data_out5,  data_out6,  data_out7,
      input  data_out8, data_out9, data_out10, data_out11, data_out12, data_out13, data_out14, data_out15,
      output out, out_q, sel_q
   );
endinterface

`default_nettype wire

// File: rtl/mux_16.sv
// mux_16: 16-way register-file read mux with an optional capture register for operand and index.
// Revision: 1.0
`default_nettype none

module mux_16 #(
   parameter int WIDTH = 16
) (
   input  wire logic clk,
   input  wire logic reset,
   mux_16_if.slave   bus
);
   localparam int c_NUM_IN = 16;

   logic [WIDTH-1:0] w_data [c_NUM_IN];
   logic [WIDTH-1:0] w_out;
   logic [WIDTH-1:0] r_out_q;
   logic [3:0]       r_sel_q;

   assign w_data[0]  = bus.data_out0;
   assign w_data[1]  = bus.data_out1;
   assign w_data[2]  = bus.data_out2;
   assign w_data[3]  = bus.data_out3;
   assign w_data[4]  = bus.data_out4;
   assign w_data[5]  = bus.data_out5;
   assign w_data[6]  = bus.data_out6;
   assign w_data[7]  = bus.data_out7;
   assign w_data[8]  = bus.data_out8;
   assign w_data[9]  = bus.data_out9;
   assign w_data[10] = bus.data_out10;
   assign w_data[11] = bus.data_out11;
   assign w_data[12] = bus.data_out12;
   assign w_data[13] = bus.data_out13;
   assign w_data[14] = bus.data_out14;
   assign w_data[15] = bus.data_out15;

   // All 16 select codes are legal, so a plain index is a complete decode.
   assign w_out = w_data[bus.select];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_out_q <= '0;
         r_sel_q <= 4'h0;
      end else if (bus.capture) begin
         r_out_q <= w_out;
         r_sel_q <= bus.select;
      end
   end

   assign bus.out   = w_out;
   assign bus.out_q = r_out_q;
   assign bus.sel_q = r_sel_q;

endmodule

`default_nettype wire

// File: tb/tb_mux_16.sv
// tb_mux_16: directed vectors for the read mux and its capture register.
// Revision: 1.0
`default_nettype none

module tb_mux_16;
   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   mux_16_if #(.WIDTH(16)) bus ();

   mux_16 #(.WIDTH(16)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_clk();
      clk = 1'b1;
      #5;
      clk = 1'b0;
      #5;
   endtask

   task automatic load_all(input logic [15:0] base_mul);
      bus.data_out0  = base_mul * 16'd1;
      bus.data_out1  = base_mul * 16'd2;
      bus.data_out2  = base_mul * 16'd3;
      bus.data_out3  = base_mul * 16'd4;
      bus.data_out4  = base_mul * 16'd5;
      bus.data_out5  = base_mul * 16'd6;
      bus.data_out6  = base_mul * 16'd7;
      bus.data_out7  = base_mul * 16'd8;
      bus.data_out8  = base_mul * 16'd9;
      bus.data_out9  = base_mul * 16'd10;
      bus.data_out10 = base_mul * 16'd11;
      bus.data_out11 = base_mul * 16'd12;
      bus.data_out12 = base_mul * 16'd13;
      bus.data_out13 = base_mul * 16'd14;
      bus.data_out14 = base_mul * 16'd15;
      bus.data_out15 = base_mul * 16'd16;
   endtask

   initial begin
      n_checks    = 0;
      n_fail      = 0;
      clk         = 1'b0;
      reset       = 1'b0;
      bus.select  = 4'd0;
      bus.capture = 1'b0;
      load_all(16'd0);
      #2;
      check("out_all_zero", 32'(bus.out), 32'h0);

      reset = 1'b1;
      #2;
      check("rst_out_q", 32'(bus.out_q), 32'h0);
      check("rst_sel_q", 32'(bus.sel_q), 32'h0);
      check("rst_out", 32'(bus.out), 32'h0);
      reset = 1'b0;
      #2;

      // Sweep with the clock idle: data_outN = 16*(N+1).
      load_all(16'd16);
      for (int s = 0; s < 16; s++) begin
         bus.select = 4'(s);
         #5;
         check($sformatf("sweep_sel%0d", s), 32'(bus.out), 32'(16 * (s + 1)));
      end

      bus.select = 4'd5;
      #5;
      check("iso_base", 32'(bus.out), 32'd96);
      bus.data_out4 = 16'hFFFF;
      bus.data_out6 = 16'hFFFF;
      #5;
      check("iso_neighbours", 32'(bus.out), 32'd96);
      bus.data_out5 = 16'hA5A5;
      #5;
      check("iso_selected", 32'(bus.out), 32'h0000A5A5);

      bus.select  = 4'd15;
      bus.capture = 1'b1;
      #2;
      pulse_clk();
      check("cap_out_q", 32'(bus.out_q), 32'd256);
      check("cap_sel_q", 32'(bus.sel_q), 32'd15);

      bus.capture = 1'b0;
      bus.select  = 4'd0;
      #2;
      pulse_clk();
      pulse_clk();
      check("hold_out_q", 32'(bus.out_q), 32'd256);
      check("hold_sel_q", 32'(bus.sel_q), 32'd15);
      check("hold_out", 32'(bus.out), 32'd16);

      // Reset between edges while the clock sits low.
      #2;
      reset = 1'b1;
      #1;
      check("async_out_q", 32'(bus.out_q), 32'h0);
      check("async_sel_q", 32'(bus.sel_q), 32'h0);
      check("async_out", 32'(bus.out), 32'd16);
      pulse_clk();
      check("rst_hold_out_q", 32'(bus.out_q), 32'h0);
      reset = 1'b0;
      #2;

      bus.select  = 4'd5;
      bus.capture = 1'b1;
      #2;
      pulse_clk();
      check("recap_out_q", 32'(bus.out_q), 32'h0000A5A5);
      check("recap_sel_q", 32'(bus.sel_q), 32'd5);
      bus.capture = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

`default_nettype wire
